// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: shared definitions for the single-step / run / breakpoint
// controller.
//   state_t          - controller FSM states
//   DIV_DEFAULT      - default run-mode clock-enable period (clock cycles)
//   DEBOUNCE_DEFAULT - default button stability time (clock cycles)
package cpu_dbg_pkg;

    typedef enum logic [1:0] {
        StHalt = 2'd0,
        StStep = 2'd1,
        StRun  = 2'd2,
        StBrk  = 2'd3
    } state_t;

    localparam int unsigned DIV_DEFAULT      = 25_000_000;
    localparam int unsigned DEBOUNCE_DEFAULT = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes a raw push-button and issues a one-cycle pulse
// when a press has been stable for CYCLES clocks.
//   i_clk   - clock, rising edge
//   i_reset - synchronous active-high reset
//   i_btn   - raw asynchronous button level
//   o_pulse - registered one-cycle pulse per accepted press
module btn_debounce
    import cpu_dbg_pkg::*;
#(
    parameter int unsigned CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int unsigned CW = $clog2(CYCLES);

    logic          r_sync0;
    logic          r_sync1;
    logic          r_vld0;
    logic          r_vld1;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_pulse;

    // r_stable resets to "pressed": a button held through reset never yields a
    // rising edge; the release must be accepted before the next press counts.
    // r_vld* mark the synchronizer as filled so its cleared reset contents are
    // never mistaken for a release.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync0  <= 1'b0;
            r_sync1  <= 1'b0;
            r_vld0   <= 1'b0;
            r_vld1   <= 1'b0;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_sync0 <= i_btn;
            r_sync1 <= r_sync0;
            r_vld0  <= 1'b1;
            r_vld1  <= r_vld0;
            r_pulse <= 1'b0;
            if (!r_vld1 || (r_sync1 == r_stable)) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(CYCLES - 1)) begin
                r_cnt    <= '0;
                r_stable <= r_sync1;
                r_pulse  <= r_sync1;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: halt / single-step / free-run / breakpoint controller that
// gates a soft core through a one-cycle clock-enable.
//   CLK100MHZ   - sole clock, rising edge
//   reset       - synchronous active-high reset
//   btn_step    - raw single-step button (debounced internally)
//   run_sw      - raw run/halt switch, 1 = run (synchronized internally)
//   pc          - core program counter
//   bp_addr     - breakpoint address
//   bp_en       - breakpoint arm
//   cpu_ce      - one-cycle clock-enable pulse, one instruction per pulse
//   halted      - 1 in HALT or BRK
//   bp_hit      - 1 in BRK
//   instr_count - number of cpu_ce pulses issued (wraps)
// Build option: define CPU_STEP_CTRL_BP_EN to enable the breakpoint logic;
// otherwise bp_addr/bp_en are ignored and BRK is unreachable.
module cpu_step_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int unsigned DIV             = DIV_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        btn_step,
    input  logic        run_sw,
    input  logic [31:0] pc,
    input  logic [31:0] bp_addr,
    input  logic        bp_en,
    output logic        cpu_ce,
    output logic        halted,
    output logic        bp_hit,
    output logic [31:0] instr_count
);

    localparam int unsigned PW = $clog2(DIV);

    state_t        r_state;
    logic          r_run_s0;
    logic          r_run_s1;
    logic [PW-1:0] r_presc;
    logic          r_cpu_ce;
    logic          r_halted;
    logic          r_bp_hit;
    logic [31:0]   r_instr_count;
    logic          w_step;
    logic          w_bp_match;

    btn_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .i_clk   (CLK100MHZ),
        .i_reset (reset),
        .i_btn   (btn_step),
        .o_pulse (w_step)
    );

`ifdef CPU_STEP_CTRL_BP_EN
    assign w_bp_match = bp_en && (pc == bp_addr);
`else
    logic w_unused_bp;
    assign w_unused_bp = ^{pc, bp_addr, bp_en};
    assign w_bp_match  = 1'b0;
`endif

    // Step pulses seen in RUN or STEP fall through the default branches and
    // are dropped. The prescaler stays cleared outside RUN.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_state       <= StHalt;
            r_run_s0      <= 1'b0;
            r_run_s1      <= 1'b0;
            r_presc       <= '0;
            r_cpu_ce      <= 1'b0;
            r_halted      <= 1'b1;
            r_bp_hit      <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_run_s0 <= run_sw;
            r_run_s1 <= r_run_s0;
            r_cpu_ce <= 1'b0;
            r_presc  <= '0;
            unique case (r_state)
                StHalt: begin
                    if (w_step) begin
                        r_state       <= StStep;
                        r_cpu_ce      <= 1'b1;
                        r_halted      <= 1'b0;
                        r_instr_count <= r_instr_count + 32'd1;
                    end else if (r_run_s1) begin
                        r_state  <= StRun;
                        r_halted <= 1'b0;
                    end
                end
                StStep: begin
                    r_state  <= StHalt;
                    r_halted <= 1'b1;
                end
                StRun: begin
                    if (!r_run_s1) begin
                        r_state  <= StHalt;
                        r_halted <= 1'b1;
                    end else if (w_bp_match) begin
                        // Breakpoint wins over a coincident prescaler tick.
                        r_state  <= StBrk;
                        r_halted <= 1'b1;
                        r_bp_hit <= 1'b1;
                    end else if (r_presc == PW'(DIV - 1)) begin
                        r_cpu_ce      <= 1'b1;
                        r_instr_count <= r_instr_count + 32'd1;
                    end else begin
                        r_presc <= r_presc + PW'(1);
                    end
                end
                StBrk: begin
                    if (w_step) begin
                        r_state       <= StStep;
                        r_cpu_ce      <= 1'b1;
                        r_halted      <= 1'b0;
                        r_bp_hit      <= 1'b0;
                        r_instr_count <= r_instr_count + 32'd1;
                    end else if (!r_run_s1) begin
                        r_state  <= StHalt;
                        r_bp_hit <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= StHalt;
                    r_halted <= 1'b1;
                    r_bp_hit <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_ce      = r_cpu_ce;
    assign halted      = r_halted;
    assign bp_hit      = r_bp_hit;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
module tb_cpu_step_ctrl;

    logic        CLK100MHZ = 1'b0;
    logic        reset;
    logic        btn_step;
    logic        run_sw;
    logic [31:0] pc;
    logic [31:0] bp_addr;
    logic        bp_en;
    logic        cpu_ce;
    logic        halted;
    logic        bp_hit;
    logic [31:0] instr_count;

    int n_pass  = 0;
    int n_total = 0;

    cpu_step_ctrl #(
        .DIV             (4),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .CLK100MHZ   (CLK100MHZ),
        .reset       (reset),
        .btn_step    (btn_step),
        .run_sw      (run_sw),
        .pc          (pc),
        .bp_addr     (bp_addr),
        .bp_en       (bp_en),
        .cpu_ce      (cpu_ce),
        .halted      (halted),
        .bp_hit      (bp_hit),
        .instr_count (instr_count)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK100MHZ);
    endtask

    // Advance n cycles, returning how many sampled cycles had cpu_ce high.
    task automatic count_ce(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(negedge CLK100MHZ);
            if (cpu_ce === 1'b1) pulses++;
        end
    endtask

    int  pulses;
    int  waited;
    bit  seen_run;
    bit  seen_brk;

    initial begin
        reset    = 1'b1;
        btn_step = 1'b0;
        run_sw   = 1'b0;
        pc       = 32'h0;
        bp_addr  = 32'h0;
        bp_en    = 1'b0;
        tick(3);
        chk("rst_halted", {31'b0, halted}, 32'd1);
        chk("rst_ce", {31'b0, cpu_ce}, 32'd0);
        chk("rst_bphit", {31'b0, bp_hit}, 32'd0);
        chk("rst_count", instr_count, 32'd0);
        reset = 1'b0;
        tick(10);

        // Long press from HALT: exactly one pulse, then back in HALT.
        btn_step = 1'b1;
        count_ce(10, pulses);
        btn_step = 1'b0;
        begin
            int more;
            count_ce(10, more);
            pulses += more;
        end
        chk("step_pulses", pulses, 32'd1);
        chk("step_count", instr_count, 32'd1);
        chk("step_halted", {31'b0, halted}, 32'd1);

        // Two-cycle glitch is rejected.
        btn_step = 1'b1;
        tick(2);
        btn_step = 1'b0;
        count_ce(12, pulses);
        chk("glitch_pulses", pulses, 32'd0);
        chk("glitch_count", instr_count, 32'd1);

        // Free run: pulse every 4th cycle; a press during RUN is dropped.
        run_sw   = 1'b1;
        seen_run = 1'b0;
        for (int i = 0; i < 10 && !seen_run; i++) begin
            tick(1);
            if (halted === 1'b0) seen_run = 1'b1;
        end
        chk("run_entry", {31'b0, seen_run}, 32'd1);
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 5) btn_step = 1'b1;
            if (i == 11) btn_step = 1'b0;
            tick(1);
            if (cpu_ce === 1'b1) pulses++;
        end
        chk("run_pulses", pulses, 32'd5);
        chk("run_count", instr_count, 32'd6);
        run_sw = 1'b0;
        count_ce(12, pulses);
        chk("run_stop_pulses", pulses, 32'd0);
        chk("run_stop_halted", {31'b0, halted}, 32'd1);
        chk("run_stop_count", instr_count, 32'd6);

        // Reset mid-RUN.
        run_sw = 1'b1;
        tick(12);
        chk("midrun_running", {31'b0, halted}, 32'd0);
        reset = 1'b1;
        tick(1);
        chk("midrun_rst_halted", {31'b0, halted}, 32'd1);
        chk("midrun_rst_ce", {31'b0, cpu_ce}, 32'd0);
        chk("midrun_rst_count", instr_count, 32'd0);
        tick(1);
        reset  = 1'b0;
        run_sw = 1'b0;
        tick(1);
        chk("midrun_post_halted", {31'b0, halted}, 32'd1);
        chk("midrun_post_count", instr_count, 32'd0);
        tick(10);

        // Button held through reset release must not step.
        btn_step = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        count_ce(15, pulses);
        chk("held_rst_pulses", pulses, 32'd0);
        btn_step = 1'b0;
        tick(10);
        btn_step = 1'b1;
        count_ce(10, pulses);
        btn_step = 1'b0;
        tick(10);
        chk("repress_pulses", pulses, 32'd1);
        chk("repress_count", instr_count, 32'd1);

        // Counter wrap.
        force dut.r_instr_count = 32'hFFFF_FFFF;
        tick(1);
        release dut.r_instr_count;
        tick(1);
        chk("wrap_preload", instr_count, 32'hFFFF_FFFF);
        btn_step = 1'b1;
        tick(10);
        btn_step = 1'b0;
        tick(10);
        chk("wrap_count", instr_count, 32'd0);

`ifdef CPU_STEP_CTRL_BP_EN
        // Breakpoint at 0xC; the bench plays the core, advancing pc per pulse.
        bp_addr  = 32'h0000_000C;
        bp_en    = 1'b1;
        pc       = 32'h0;
        run_sw   = 1'b1;
        pulses   = 0;
        seen_brk = 1'b0;
        for (int i = 0; i < 60 && !seen_brk; i++) begin
            tick(1);
            if (cpu_ce === 1'b1) begin
                pulses++;
                pc = pc + 32'd4;
            end
            if (bp_hit === 1'b1) seen_brk = 1'b1;
        end
        chk("bp_reached", {31'b0, seen_brk}, 32'd1);
        chk("bp_pc", pc, 32'h0000_000C);
        chk("bp_pulses", pulses, 32'd3);
        chk("bp_halted", {31'b0, halted}, 32'd1);
        count_ce(10, pulses);
        chk("bp_hold_pulses", pulses, 32'd0);
        chk("bp_hold_hit", {31'b0, bp_hit}, 32'd1);
        // Step out of BRK: one pulse, then the HALT cycle.
        btn_step = 1'b1;
        waited   = 0;
        while (cpu_ce !== 1'b1 && waited < 20) begin
            tick(1);
            waited++;
        end
        chk("bp_step_pulse", {31'b0, cpu_ce}, 32'd1);
        pc = pc + 32'd4;
        tick(1);
        chk("bp_step_halt", {31'b0, halted}, 32'd1);
        chk("bp_step_hit", {31'b0, bp_hit}, 32'd0);
        btn_step = 1'b0;
        run_sw   = 1'b0;
        tick(12);
        chk("bp_final_halted", {31'b0, halted}, 32'd1);
`else
        // Breakpoint logic absent: a matching armed address is ignored.
        bp_addr = 32'h0000_0000;
        bp_en   = 1'b1;
        pc      = 32'h0;
        run_sw  = 1'b1;
        count_ce(16, pulses);
        chk("nobp_running", {31'b0, halted}, 32'd0);
        chk("nobp_hit", {31'b0, bp_hit}, 32'd0);
        chk("nobp_pulses_ge3", {31'b0, (pulses >= 3)}, 32'd1);
        run_sw = 1'b0;
        tick(8);
        chk("nobp_halted", {31'b0, halted}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
